// File: rtl/mram_read_sequencer_pkg.sv
// Shared types and constants for the MRAM read sequencer.
// State encoding, word-select codes and serial bit counts.
package mram_read_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_LOAD    = 3'd4,
    ST_SHIFT   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] WS_FULL    = 2'b11;
  localparam logic [1:0] WS_UPPER   = 2'b10;
  localparam logic [1:0] WS_LOWER   = 2'b01;
  localparam logic [1:0] WS_ILLEGAL = 2'b00;

  localparam logic [4:0] NBITS_FULL = 5'd16;
  localparam logic [4:0] NBITS_BYTE = 5'd8;

  function automatic logic [4:0] nbits(input logic [1:0] sel);
    return (sel == WS_FULL) ? NBITS_FULL : NBITS_BYTE;
  endfunction

endpackage

// File: rtl/mram_read_sequencer.sv
// Runs one asynchronous MRAM read and hands the captured word to the
// parallel-to-serial shifter, marking each valid serial bit.
module mram_read_sequencer
  import mram_read_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int READ_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [1:0]        word_sel_in,
  input  logic [15:0]       mram_dq,
  output logic [ADDR_W-1:0] mram_addr,
  output logic              mram_ce_n,
  output logic              mram_oe_n,
  output logic [15:0]       p2s_data,
  output logic              p2s_load,
  output logic              p2s_send,
  output logic [1:0]        p2s_word_sel,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [4:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       data_q, data_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              load_q, load_d;
  logic              send_q, send_d;
  logic              bv_q, bv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      load_q  <= 1'b0;
      send_q  <= 1'b0;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      load_q  <= load_d;
      send_q  <= send_d;
      bv_q    <= bv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    busy_d  = busy_q;
    load_d  = 1'b0;
    send_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // serializer registers data_out, so the valid flag trails send by one
    bv_d    = send_q;

    unique case (state_q)
      ST_IDLE: begin
        // a start colliding with the done pulse is dropped
        if (start && !done_q) begin
          addr_d = addr_in;
          sel_d  = word_sel_in;
          busy_d = 1'b1;
          if (word_sel_in == WS_ILLEGAL) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        wcnt_d  = 4'(READ_WAIT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        data_d  = mram_dq;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        load_d  = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        send_d  = 1'b1;
        bcnt_d  = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bcnt_q == nbits(sel_q) - 5'd1) begin
          state_d = ST_DONE;
        end else begin
          send_d = 1'b1;
          bcnt_d = bcnt_q + 5'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        err_d   = (sel_q == WS_ILLEGAL);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mram_addr    = addr_q;
  assign mram_ce_n    = ce_n_q;
  assign mram_oe_n    = oe_n_q;
  assign p2s_data     = data_q;
  assign p2s_load     = load_q;
  assign p2s_send     = send_q;
  assign p2s_word_sel = sel_q;
  assign bit_valid    = bv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mram_read_sequencer.sv
// Bench: sequencer plus behavioural MRAM and serializer, checked each cycle
// against a transaction timeline model, with directed and random stimulus.
module tb_mram_read_sequencer;
  import mram_read_sequencer_pkg::*;

  localparam int AW = 18;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [1:0]    word_sel_in = '0;
  logic [15:0]   mram_dq;
  logic [AW-1:0] mram_addr;
  logic          mram_ce_n, mram_oe_n;
  logic [15:0]   p2s_data;
  logic          p2s_load, p2s_send;
  logic [1:0]    p2s_word_sel;
  logic          bit_valid, busy, done, err;

  always #5 clk = ~clk;

  mram_read_sequencer #(.ADDR_W(AW), .READ_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .addr_in(addr_in), .word_sel_in(word_sel_in),
    .mram_dq(mram_dq), .mram_addr(mram_addr),
    .mram_ce_n(mram_ce_n), .mram_oe_n(mram_oe_n),
    .p2s_data(p2s_data), .p2s_load(p2s_load), .p2s_send(p2s_send),
    .p2s_word_sel(p2s_word_sel), .bit_valid(bit_valid),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [15:0] mdata(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5D3 ^ {14'd0, a[17:16]};
  endfunction

  // MRAM: data only valid after RW cycles of ce/oe low
  int low_cnt = 0;
  always @(posedge clk) begin
    if (!mram_ce_n && !mram_oe_n) low_cnt <= low_cnt + 1;
    else low_cnt <= 0;
  end
  assign mram_dq = (!mram_ce_n && !mram_oe_n && low_cnt >= RW)
                   ? mdata(mram_addr) : ~mdata(mram_addr);

  // serializer sharing en: load word, shift MSB first, registered out
  logic [15:0] ser_sr;
  logic [3:0]  ser_idx;
  logic        ser_out;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_sr <= '0; ser_idx <= '0; ser_out <= 1'b0;
    end else if (en) begin
      if (p2s_load) begin
        ser_sr  <= p2s_data;
        ser_idx <= (p2s_word_sel == WS_LOWER) ? 4'd7 : 4'd15;
      end else if (p2s_send) begin
        ser_out <= ser_sr[ser_idx];
        ser_idx <= ser_idx - 4'd1;
      end
    end
  end

  // model: one transaction timeline indexed by enabled-edge ticks
  int            tick = 0, m_s = 0, m_n = 0, m_t = 0;
  bit            m_act = 0, m_legal = 0;
  logic [AW-1:0] m_addr = '0;
  logic [1:0]    m_sel = '0;
  logic [15:0]   m_dat = '0, m_prev = '0;

  int          k;
  logic        e_busy, e_done, e_err, e_ce_n, e_load, e_send, e_bv, e_bit;
  logic [15:0] e_data;

  always_comb begin
    k = tick - m_s;
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ce_n = 1'b1;
    e_load = 1'b0; e_send = 1'b0; e_bv = 1'b0; e_bit = 1'b0;
    e_data = m_prev;
    if (m_act) begin
      e_busy = (k >= 1) && (k <= m_t - 1);
      e_done = (k == m_t);
      e_err  = e_done && !m_legal;
      if (m_legal) begin
        e_ce_n = !((k >= 2) && (k <= 5));
        e_load = (k == 6);
        e_send = (k >= 7) && (k <= 6 + m_n);
        e_bv   = (k >= 8) && (k <= 7 + m_n);
        if (k >= 6) e_data = m_dat;
        if (e_bv)
          e_bit = m_dat[((m_sel == WS_LOWER) ? 7 : 15) - (k - 8)];
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 0; m_act <= 0; m_s <= 0; m_t <= 0; m_n <= 0;
      m_addr <= '0; m_sel <= '0; m_dat <= '0; m_prev <= '0;
      m_legal <= 0;
    end else if (en) begin
      tick <= tick + 1;
      if (start && (!m_act || (tick - m_s) > m_t)) begin
        m_act   <= 1;
        m_s     <= tick;
        m_addr  <= addr_in;
        m_sel   <= word_sel_in;
        m_legal <= (word_sel_in != WS_ILLEGAL);
        m_n     <= (word_sel_in == WS_FULL) ? 16 : 8;
        m_t     <= (word_sel_in == WS_ILLEGAL) ? 2 :
                   ((word_sel_in == WS_FULL) ? 24 : 16);
        m_dat   <= mdata(addr_in);
        m_prev  <= e_data;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // stream capture and per-transaction observations for directed tests
  logic [15:0] stream = '0;
  int          slen = 0, last_tick = -1, busy_cyc = 0;
  bit          ce_seen = 0;

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("ce_n", 32'(mram_ce_n), 32'(e_ce_n));
    chk("oe_n", 32'(mram_oe_n), 32'(e_ce_n));
    chk("load", 32'(p2s_load), 32'(e_load));
    chk("send", 32'(p2s_send), 32'(e_send));
    chk("bit_valid", 32'(bit_valid), 32'(e_bv));
    chk("mram_addr", 32'(mram_addr), 32'(m_addr));
    chk("word_sel", 32'(p2s_word_sel), 32'(m_sel));
    chk("p2s_data", 32'(p2s_data), 32'(e_data));
    if (e_bv) chk("serial_bit", 32'(ser_out), 32'(e_bit));
    if (bit_valid && tick != last_tick) begin
      stream    = {stream[14:0], ser_out};
      slen      = slen + 1;
      last_tick = tick;
    end
    if (busy) busy_cyc = busy_cyc + 1;
    if (!mram_ce_n) ce_seen = 1;
  end

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] s,
                         input int stall_at, output int lat,
                         output logic err_at_done);
    @(negedge clk);
    stream = '0; slen = 0; last_tick = -1; busy_cyc = 0; ce_seen = 0;
    start = 1'b1; addr_in = a; word_sel_in = s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        addr_in = AW'($urandom);
        word_sel_in = 2'($urandom);
      end
      if (lat == stall_at) en = 1'b0;
      if (lat == stall_at + 5) en = 1'b1;
    end while (!done && lat < 200);
    chk("done_seen", 32'(done), 32'd1);
    err_at_done = err;
    en = 1'b1;
  endtask

  int   lat, dcount;
  logic e_at;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ce_n", 32'(mram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(mram_oe_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(mram_addr), 32'd0);
    rst = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);

    do_read(18'h00010, WS_FULL, 0, lat, e_at);
    chk("t1_lat", lat, 24);
    chk("t1_word", 32'(stream), 32'hA5C3);
    chk("t1_len", slen, 16);
    chk("t1_busy_cyc", busy_cyc, 23);

    do_read(18'h00010, WS_UPPER, 0, lat, e_at);
    chk("t2_lat", lat, 16);
    chk("t2_byte", 32'(stream[7:0]), 32'hA5);
    chk("t2_len", slen, 8);

    do_read(18'h00010, WS_LOWER, 0, lat, e_at);
    chk("t3_byte", 32'(stream[7:0]), 32'hC3);
    chk("t3_err", 32'(e_at), 32'd0);
    chk("t3_len", slen, 8);

    do_read(18'h00010, WS_ILLEGAL, 0, lat, e_at);
    chk("t4_lat", lat, 2);
    chk("t4_err", 32'(e_at), 32'd1);
    chk("t4_busy_cyc", busy_cyc, 1);
    chk("t4_ce_seen", 32'(ce_seen), 32'd0);
    chk("t4_len", slen, 0);

    do_read(18'h23456, WS_FULL, 12, lat, e_at);
    chk("t5_lat", lat, 29);
    chk("t5_word", 32'(stream), 32'h9187);
    chk("t5_len", slen, 16);

    @(negedge clk);
    start = 1'b1; addr_in = 18'h00155; word_sel_in = WS_FULL;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_ce_pre", 32'(mram_ce_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_ce_n", 32'(mram_ce_n), 32'd1);
    chk("t6_oe_n", 32'(mram_oe_n), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("t6_no_done", dcount, 0);
    do_read(18'h00010, WS_FULL, 0, lat, e_at);
    chk("t6_lat", lat, 24);
    chk("t6_word", 32'(stream), 32'hA5C3);

    repeat (3000) begin
      @(negedge clk);
      start       = ($urandom_range(0, 5) == 0);
      addr_in     = AW'($urandom);
      word_sel_in = 2'($urandom);
      en          = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
